rr_mux: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes. Each cycle it selects one channel, either fixed by `sel` or by round-robin arbitration, and loads that channel's word into a single output register. It succeeds the combinational 8:1 mux in datapaths where several producers share one consumer and flow control is required.

---
 rtl/rr_mux.sv | 107 ++++++++++
 tb/tb_rr_mux.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux.sv
// N-channel registered multiplexer with per-channel valid/ready handshakes.
// Channels are picked by a fixed select or by round-robin arbitration.
module rr_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int SELW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    dbg_ptr
);

  // Handshake: a channel word moves on a rising edge where in_valid[i] & in_ready[i];
  // the output word is consumed on an edge where out_valid & out_ready.

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en;
  logic             gnt_any;
  logic             xfer;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  cand;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] ch_data [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  assign load_en = !out_valid_q || out_ready;

  // Round-robin scans from the highest offset down so the last hit is the first in search order.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        cand = SELW'((int'(ptr_q) + k) % N);
        if (in_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign grant    = gnt_any ? (N'(1) << gnt_idx) : '0;
  assign in_ready = (load_en && !rst) ? grant : '0;
  assign xfer     = gnt_any && load_en;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = ch_data[gnt_idx];
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SELW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: vector table, hand-written corner sequences, and random traffic
// checked against a queue-based arbitration model.
`timescale 1ns/1ps
module tb_rr_mux;
  localparam int W  = 8;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int N5 = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid, in_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_ch, dbg_ptr;
  logic          out_valid, out_ready;

  logic           mode5;
  logic [SW-1:0]  sel5;
  logic [N5*W-1:0] in_data5;
  logic [N5-1:0]  in_valid5, in_ready5;
  logic [W-1:0]   out_data5;
  logic [SW-1:0]  out_ch5, dbg_ptr5;
  logic           out_valid5, out_ready5;

  rr_mux #(.WIDTH(W), .N(N), .SELW(SW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .dbg_ptr(dbg_ptr)
  );

  rr_mux #(.WIDTH(W), .N(N5), .SELW(SW)) dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5), .in_data(in_data5),
    .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5), .out_ch(out_ch5),
    .out_valid(out_valid5), .out_ready(out_ready5), .dbg_ptr(dbg_ptr5)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard + reference model state
  logic [W+SW-1:0] exp_q[$];
  int         m_ptr;
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_ch;

  typedef struct {
    bit            mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  valid;
    bit            exp_ov;
    logic [SW-1:0] exp_ch;
    logic [W-1:0]  exp_data;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    exp_q.delete();
  endtask

  task automatic set_data(input int base);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(base + i);
  endtask

  task automatic add_vec(input bit md, input int s, input logic [N-1:0] v,
                         input bit ov, input int ch, input int data);
    vec_t e;
    e.mode = md; e.sel = SW'(s); e.valid = v;
    e.exp_ov = ov; e.exp_ch = SW'(ch); e.exp_data = W'(data);
    vecs.push_back(e);
  endtask

  // Grant from the rules: fixed index, or first valid in the rotated channel list.
  function automatic int ref_grant();
    int order[$];
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
    foreach (order[j]) if (in_valid[order[j]]) return order[j];
    return -1;
  endfunction

  // driver: one clock cycle on the 8-channel instance, checked against the model
  task automatic tick();
    int g;
    bit load;
    logic [N-1:0] exp_rdy;
    logic [W+SW-1:0] e;
    #1;
    load = !m_valid || out_ready;
    g = ref_grant();
    exp_rdy = '0;
    if (load && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (m_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty actual=none expected=word");
      end else begin
        e = exp_q.pop_front();
        chk("sb_word", 64'({out_ch, out_data}), 64'(e));
      end
    end
    @(posedge clk);
    if (load && g >= 0) begin
      m_data  = in_data[g*W +: W];
      m_ch    = g;
      m_valid = 1'b1;
      if (mode) m_ptr = (g + 1) % N;
      exp_q.push_back({SW'(g), m_data});
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data", 64'(out_data), 64'(m_data));
    chk("out_ch", 64'(out_ch), 64'(m_ch));
    chk("ptr", 64'(dbg_ptr), 64'(m_ptr));
  endtask

  initial begin
    rst = 1'b1;
    mode = 1'b0; sel = '0; in_valid = '1; out_ready = 1'b1;
    set_data(8'h10);
    mode5 = 1'b1; sel5 = '0; in_valid5 = '0; out_ready5 = 1'b1;
    for (int i = 0; i < N5; i++) in_data5[i*W +: W] = W'(8'h50 + i);
    m_reset();
    #12;
    chk("rst_ov", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_ch", 64'(out_ch), 64'(0));
    chk("rst_rdy", 64'(in_ready), 64'(0));
    chk("rst_ptr", 64'(dbg_ptr), 64'(0));
    rst = 1'b0;

    // vector table: fixed sweep, missing channel, fairness, two-channel alternation
    for (int s = 0; s < N; s++) add_vec(1'b0, s, 8'hFF, 1'b1, s, 8'h10 + s);
    add_vec(1'b0, 3, 8'hF7, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) add_vec(1'b1, 0, 8'hFF, 1'b1, i % 8, 8'h10 + i % 8);
    for (int i = 0; i < 4; i++) add_vec(1'b1, 0, 8'h24, 1'b1, (i % 2) ? 5 : 2, (i % 2) ? 8'h15 : 8'h12);
    foreach (vecs[i]) begin
      mode = vecs[i].mode; sel = vecs[i].sel; in_valid = vecs[i].valid; out_ready = 1'b1;
      tick();
      chk("tbl_ov", 64'(out_valid), 64'(vecs[i].exp_ov));
      if (vecs[i].exp_ov) begin
        chk("tbl_ch", 64'(out_ch), 64'(vecs[i].exp_ch));
        chk("tbl_data", 64'(out_data), 64'(vecs[i].exp_data));
      end
    end

    // backpressure
    mode = 1'b0; sel = 3'd1; in_data[1*W +: W] = 8'hA5; in_valid = '1; out_ready = 1'b1;
    tick();
    chk("bp_load", 64'(out_data), 64'(8'hA5));
    mode = 1'b1; out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("bp_rdy", 64'(in_ready), 64'(0));
      chk("bp_data", 64'(out_data), 64'(8'hA5));
      chk("bp_ptr", 64'(dbg_ptr), 64'(6));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_next_ch", 64'(out_ch), 64'(6));
    chk("bp_next_data", 64'(out_data), 64'(8'h16));
    set_data(8'h10);

    // mode switch
    in_valid = 8'h04;
    tick();
    chk("ms_ptr", 64'(dbg_ptr), 64'(3));
    mode = 1'b0; sel = 3'd6; in_valid = '1;
    repeat (2) begin
      tick();
      chk("ms_fixed_ch", 64'(out_ch), 64'(6));
      chk("ms_ptr_hold", 64'(dbg_ptr), 64'(3));
    end
    mode = 1'b1;
    tick();
    chk("ms_rr_ch", 64'(out_ch), 64'(3));

    // five-channel wrap, main instance idle
    in_valid = '0;
    in_valid5 = 5'b10000;
    #1 chk("w5_rdy", 64'(in_ready5), 64'(5'b10000));
    tick();
    chk("w5_ch", 64'(out_ch5), 64'(4));
    chk("w5_data", 64'(out_data5), 64'(8'h54));
    chk("w5_ptr", 64'(dbg_ptr5), 64'(0));
    in_valid5 = 5'b01000;
    tick();
    chk("w5_ptr4", 64'(dbg_ptr5), 64'(4));
    in_valid5 = 5'b10001;
    tick(); chk("w5_ord0", 64'(out_ch5), 64'(4));
    tick(); chk("w5_ord1", 64'(out_ch5), 64'(0));
    tick(); chk("w5_ord2", 64'(out_ch5), 64'(4));
    mode5 = 1'b0; sel5 = 3'd6; in_valid5 = '1;
    #1 chk("w5_sel_oob_rdy", 64'(in_ready5), 64'(0));
    tick();
    chk("w5_sel_oob_ov", 64'(out_valid5), 64'(0));
    mode5 = 1'b1; in_valid5 = '0;

    // asynchronous reset mid-cycle with a word held
    mode = 1'b1; in_valid = '1;
    tick();
    chk("ar_pre_ov", 64'(out_valid), 64'(1));
    #3 rst = 1'b1;
    #1;
    chk("ar_ov", 64'(out_valid), 64'(0));
    chk("ar_data", 64'(out_data), 64'(0));
    chk("ar_ch", 64'(out_ch), 64'(0));
    chk("ar_rdy", 64'(in_ready), 64'(0));
    chk("ar_ptr", 64'(dbg_ptr), 64'(0));
    m_reset();
    #2 rst = 1'b0;
    tick();
    chk("ar_first_rr", 64'(out_ch), 64'(0));

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      mode = 1'($urandom_range(0, 1));
      sel = SW'($urandom_range(0, N - 1));
      in_valid = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
      tick();
    end
    chk("sb_left", 64'(exp_q.size() <= 1), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
